if_id_branch_unit: RTL

- ID-side counterpart of the instruction-fetch stage.
- Holds the IF/ID pipeline register and decodes the held instruction.
- Detects load-use and branch-operand hazards.
- Resolves beq/bne in ID. Drives the fetch stage's stall, branch_confirm and branch_addr inputs, and consumes its PC+4 and instruction outputs.

---
 rtl/if_id_branch_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/if_id_branch_unit.sv
// IF/ID pipeline register with decode, load-use/branch hazard detection and ID-stage beq/bne resolution.
// Optional hazard statistics counters are enabled by defining HAZARD_STATS_EN.
module if_id_branch_unit #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    parameter int          STAT_W   = 16
) (
    input  logic        CPUCLK,
    input  logic        reset,
    input  logic [31:0] inst_in,
    input  logic [31:0] pc_add_4_in,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_rd,
    output logic [31:0] instr_id,
    output logic [31:0] pc_add_4_id,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic        stall,
    output logic        id_bubble,
    output logic        branch_confirm,
    output logic [31:0] branch_addr
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt,
    output logic [STAT_W-1:0] branch_cnt
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // A producer register matches the ID instruction's sources; $0 never matches.
    function automatic logic reg_match(input logic [4:0] r, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic uses_rt);
        reg_match = (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic [5:0]  op_s;
    logic        is_beq_s, is_bne_s, is_branch_s, uses_rt_s;
    logic        load_use_s, br_ex_s, br_mem_s, stall_s;
    logic        operands_eq_s, branch_confirm_s;
    logic [31:0] branch_off_s;

    // Opcode decode of the held instruction.
    always_comb begin
        op_s      = instr_q[31:26];
        is_beq_s  = 1'b0;
        is_bne_s  = 1'b0;
        uses_rt_s = 1'b0;
        case (op_s)
            OP_RTYPE: uses_rt_s = 1'b1;
            OP_BEQ: begin
                is_beq_s  = 1'b1;
                uses_rt_s = 1'b1;
            end
            OP_BNE: begin
                is_bne_s  = 1'b1;
                uses_rt_s = 1'b1;
            end
            OP_SW:    uses_rt_s = 1'b1;
            default:  uses_rt_s = 1'b0;
        endcase
        is_branch_s = is_beq_s | is_bne_s;
    end

    // Hazard detection and branch resolution; a stalled branch never confirms.
    always_comb begin
        load_use_s = ex_mem_read && reg_match(ex_rd, instr_q[25:21], instr_q[20:16], uses_rt_s);
        br_ex_s    = is_branch_s && ex_reg_write
                     && reg_match(ex_rd, instr_q[25:21], instr_q[20:16], uses_rt_s);
        br_mem_s   = is_branch_s && mem_mem_read
                     && reg_match(mem_rd, instr_q[25:21], instr_q[20:16], uses_rt_s);
        stall_s    = load_use_s | br_ex_s | br_mem_s;
        operands_eq_s    = (rs_data == rt_data);
        branch_confirm_s = is_branch_s && !stall_s
                           && (is_beq_s ? operands_eq_s : !operands_eq_s);
        branch_off_s     = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    end

    // IF/ID next state: hold on stall, flush on taken branch, else advance.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        if (stall_s) begin
            instr_d = instr_q;
            pc4_d   = pc4_q;
        end else if (branch_confirm_s) begin
            instr_d = NOP_WORD;
            pc4_d   = 32'h0000_0000;
        end else begin
            instr_d = inst_in;
            pc4_d   = pc_add_4_in;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge CPUCLK or posedge reset) begin
        if (reset) begin
            instr_q <= NOP_WORD;
            pc4_q   <= 32'h0000_0000;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    assign instr_id       = instr_q;
    assign pc_add_4_id    = pc4_q;
    assign rs_addr        = instr_q[25:21];
    assign rt_addr        = instr_q[20:16];
    assign stall          = stall_s;
    assign id_bubble      = stall_s;
    assign branch_confirm = branch_confirm_s;
    assign branch_addr    = pc4_q + branch_off_s;

`ifdef HAZARD_STATS_EN
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [STAT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;

    // Saturating event counters.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        branch_cnt_d = branch_cnt_q;
        if (stall_s && (stall_cnt_q != {STAT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STAT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (branch_confirm_s && (flush_cnt_q != {STAT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + STAT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
        if (is_branch_s && !stall_s && (branch_cnt_q != {STAT_W{1'b1}})) begin
            branch_cnt_d = branch_cnt_q + STAT_ONE;
        end else begin
            branch_cnt_d = branch_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge CPUCLK or posedge reset) begin
        if (reset) begin
            stall_cnt_q  <= {STAT_W{1'b0}};
            flush_cnt_q  <= {STAT_W{1'b0}};
            branch_cnt_q <= {STAT_W{1'b0}};
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            branch_cnt_q <= branch_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign branch_cnt = branch_cnt_q;
`else
    logic unused_stat_w_s;
    assign unused_stat_w_s = (STAT_W > 0);
`endif

endmodule
